// File: rtl/jtcop_pkg.sv
// Shared definitions for the object DMA block.
//   OBJ_AW      : default object RAM / buffer word-address width
//   dma_state_t : copy sequencer state encoding
package jtcop_pkg;

  localparam int OBJ_AW = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_READ = 2'd2,
    ST_LAST = 2'd3
  } dma_state_t;

endpackage

// File: rtl/jtcop_obj_dma.sv
// Object RAM to object buffer DMA. A rising edge on obj_copy copies all
// 2^AW words of object RAM into the object buffer in ascending order,
// one word per cen-high cycle.
//
// Ports
//   rst        in   async active-high reset
//   clk        in   system clock
//   cen        in   word pacing enable
//   LVBL       in   active-low vertical blank
//   obj_copy   in   copy request level from CPU decode
//   ram_addr   out  object RAM read address (AW bits)
//   ram_dout   in   object RAM data, one clk after ram_addr
//   buf_addr   out  object buffer write address (AW bits)
//   buf_din    out  object buffer write data
//   buf_we     out  object buffer write strobe
//   busy       out  copy in progress
//   done       out  one-clk pulse after the last word is written
//
// Build option
//   JTCOP_OBJ_DMA_WAITVB_EN : when defined, a copy only starts on the clk
//   after LVBL falls. When undefined, LVBL is ignored.
//
// state   | meaning
// IDLE    | no copy in progress
// WAIT    | request accepted, waiting for the start condition
// READ    | streaming words 0 .. 2^AW-2 (first cen only primes the read)
// LAST    | address counter wrapped, last word still to be written
module jtcop_obj_dma
  import jtcop_pkg::*;
#(
  parameter int AW = OBJ_AW
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen,
  input  logic          LVBL,
  input  logic          obj_copy,
  output logic [AW-1:0] ram_addr,
  input  logic [15:0]   ram_dout,
  output logic [AW-1:0] buf_addr,
  output logic [15:0]   buf_din,
  output logic          buf_we,
  output logic          busy,
  output logic          done
);

  dma_state_t    state_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic [AW-1:0] wr_q;
  logic [AW-1:0] buf_addr_q;
  logic [15:0]   data_q;
  logic [15:0]   word_d;
  logic [15:0]   buf_din_q;
  logic          primed_q;
  logic          cap_q;
  logic          copy_q;
  logic          pend_q;
  logic          buf_we_q;
  logic          done_q;
  logic          req_d;
  logic          start_d;

  assign req_d = obj_copy & ~copy_q;
  assign cnt_d = cnt_q + {{AW{1'b0}}, 1'b1};

  // RAM data for the address issued on the last advance is valid exactly
  // one clk after that advance (cap_q high). With back-to-back cen it is
  // used straight from ram_dout; with slower cen it is parked in data_q
  // because ram_dout moves on to the next address.
  assign word_d = cap_q ? ram_dout : data_q;

`ifdef JTCOP_OBJ_DMA_WAITVB_EN
  logic lvbl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvbl_q <= 1'b0;
    else     lvbl_q <= LVBL;
  end

  assign start_d = lvbl_q & ~LVBL;
`else
  logic unused_lvbl;

  assign unused_lvbl = LVBL;
  assign start_d     = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_q       <= '0;
      data_q     <= '0;
      primed_q   <= 1'b0;
      cap_q      <= 1'b0;
      copy_q     <= 1'b0;
      pend_q     <= 1'b0;
      buf_addr_q <= '0;
      buf_din_q  <= '0;
      buf_we_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      copy_q   <= obj_copy;
      buf_we_q <= 1'b0;
      done_q   <= 1'b0;
      cap_q    <= 1'b0;
      if (cap_q) data_q <= ram_dout;

      case (state_q)
        ST_IDLE: begin
          pend_q <= 1'b0;
          if (req_d) state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          if (req_d) pend_q <= 1'b1;
          cnt_q    <= '0;
          primed_q <= 1'b0;
          if (start_d) state_q <= ST_READ;
        end

        ST_READ: begin
          if (req_d) pend_q <= 1'b1;
          if (cen) begin
            // wr_q trails the read address by one word: it is the word
            // whose data arrives on the next clk.
            cnt_q    <= cnt_d;
            wr_q     <= cnt_q[AW-1:0];
            cap_q    <= 1'b1;
            primed_q <= 1'b1;
            if (primed_q) begin
              buf_we_q   <= 1'b1;
              buf_addr_q <= wr_q;
              buf_din_q  <= word_d;
            end
            if (cnt_d[AW]) state_q <= ST_LAST;
          end
        end

        ST_LAST: begin
          if (cen) begin
            buf_we_q   <= 1'b1;
            buf_addr_q <= wr_q;
            buf_din_q  <= word_d;
            done_q     <= 1'b1;
            pend_q     <= 1'b0;
            // A request landing on this very clk is folded into pending.
            if (pend_q || req_d) state_q <= ST_WAIT;
            else                 state_q <= ST_IDLE;
          end else if (req_d) begin
            pend_q <= 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ram_addr = cnt_q[AW-1:0];
  assign buf_addr = buf_addr_q;
  assign buf_din  = buf_din_q;
  assign buf_we   = buf_we_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

endmodule
